// File: rtl/scope_trace_renderer.sv
// scope_trace_renderer: triggered capture of ADC samples into a double-buffered
// line store, rendered as a single-pixel trace over a graticule with 2-cycle latency.
module scope_trace_renderer #(
    parameter int WIDTH        = 640,
    parameter int HEIGHT       = 480,
    parameter int GRID_LOG2    = 4,
    parameter int AUTO_TIMEOUT = 65535
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sample,
    input  logic       sample_valid,
    input  logic [7:0] trigger_level,
    input  logic [9:0] CounterX,
    input  logic [9:0] CounterY,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic       armed,
    output logic       auto_trig
);
    localparam int AW = $clog2(WIDTH);
    localparam int TW = $clog2(AUTO_TIMEOUT + 1);

    typedef enum logic [1:0] {ARMED, CAPTURE, HOLD} state_e;

    state_e          state_q, state_d;
    logic [7:0]      prev_q, prev_d;
    logic            prev_ok_q, prev_ok_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic            cap_bank_q, cap_bank_d;
    logic            disp_valid_q, disp_valid_d;
    logic            auto_pending_q, auto_pending_d;
    logic            auto_trig_q, auto_trig_d;
    logic            we;
    logic [AW-1:0]   wa;
    logic [7:0]      bank0 [WIDTH];
    logic [7:0]      bank1 [WIDTH];
    logic [7:0]      rd_q;
    logic [9:0]      x1_q, y1_q, ytr;
    logic [23:0]     rgb_q, rgb_d;
    logic            hit, forced, boundary, vis, trace, grid;

    assign hit      = prev_ok_q && prev_q < trigger_level && sample >= trigger_level;
    assign forced   = tmo_q == TW'(AUTO_TIMEOUT - 1);
    assign boundary = CounterX == 10'd0 && CounterY == 10'(HEIGHT);

    always_comb begin
        state_d        = state_q;
        prev_d         = prev_q;
        prev_ok_d      = prev_ok_q;
        tmo_d          = tmo_q;
        waddr_d        = waddr_q;
        cap_bank_d     = cap_bank_q;
        disp_valid_d   = disp_valid_q;
        auto_pending_d = auto_pending_q;
        auto_trig_d    = auto_trig_q;
        we             = 1'b0;
        wa             = waddr_q;
        case (state_q)
            ARMED: if (sample_valid) begin
                prev_d    = sample;
                prev_ok_d = 1'b1;
                tmo_d     = tmo_q + 1'b1;
                // a real edge wins over the timeout, so the record is not flagged auto
                if (hit || forced) begin
                    we             = 1'b1;
                    wa             = '0;
                    waddr_d        = AW'(1);
                    auto_pending_d = !hit;
                    state_d        = CAPTURE;
                end
            end
            CAPTURE: if (sample_valid) begin
                we      = 1'b1;
                waddr_d = waddr_q + 1'b1;
                if (waddr_q == AW'(WIDTH - 1)) state_d = HOLD;
            end
            HOLD: if (boundary) begin
                cap_bank_d   = !cap_bank_q;
                disp_valid_d = 1'b1;
                auto_trig_d  = auto_pending_q;
                prev_ok_d    = 1'b0;
                tmo_d        = '0;
                state_d      = ARMED;
            end
            default: state_d = ARMED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (we && !cap_bank_q) bank0[wa] <= sample;
        if (we && cap_bank_q) bank1[wa] <= sample;
        if (CounterX < 10'(WIDTH)) rd_q <= cap_bank_q ? bank0[CounterX[AW-1:0]] : bank1[CounterX[AW-1:0]];
    end

    assign ytr   = 10'(HEIGHT - 1) - 10'((18'(rd_q) * 18'(HEIGHT)) >> 8);
    assign vis   = x1_q < 10'(WIDTH) && y1_q < 10'(HEIGHT);
    assign trace = vis && disp_valid_q && y1_q == ytr;
    assign grid  = vis && (x1_q[GRID_LOG2-1:0] == '0 || y1_q[GRID_LOG2-1:0] == '0);
    assign rgb_d = trace ? 24'h00FF00 : grid ? 24'h404040 : 24'h000000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ARMED;
            prev_q         <= '0;
            prev_ok_q      <= 1'b0;
            tmo_q          <= '0;
            waddr_q        <= '0;
            cap_bank_q     <= 1'b0;
            disp_valid_q   <= 1'b0;
            auto_pending_q <= 1'b0;
            auto_trig_q    <= 1'b0;
            x1_q           <= '0;
            y1_q           <= '0;
            rgb_q          <= '0;
        end else begin
            state_q        <= state_d;
            prev_q         <= prev_d;
            prev_ok_q      <= prev_ok_d;
            tmo_q          <= tmo_d;
            waddr_q        <= waddr_d;
            cap_bank_q     <= cap_bank_d;
            disp_valid_q   <= disp_valid_d;
            auto_pending_q <= auto_pending_d;
            auto_trig_q    <= auto_trig_d;
            x1_q           <= CounterX;
            y1_q           <= CounterY;
            rgb_q          <= rgb_d;
        end
    end

    assign {red, green, blue} = rgb_q;
    assign armed              = state_q == ARMED;
    assign auto_trig          = auto_trig_q;
endmodule

// File: tb/tb_scope_trace_renderer.sv
// tb_scope_trace_renderer: directed sequence with random record data, checked
// against a queue-based record model and an arithmetic pixel colour model.
module tb_scope_trace_renderer;
    localparam int W = 640;
    localparam int H = 480;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] sample = '0;
    logic       sample_valid = 1'b0;
    logic [7:0] trigger_level = 8'd100;
    logic [9:0] CounterX = 10'd700;
    logic [9:0] CounterY = 10'd500;
    logic [7:0] red, green, blue;
    logic       armed, auto_trig;

    int total = 0;
    int bad = 0;

    int disp [W];
    int pend [$];
    bit m_valid = 0, m_auto = 0, m_pauto = 0, m_prev_ok = 0;
    int m_prev = 0, m_cnt = 0;

    always #5 clk = ~clk;

    scope_trace_renderer #(.WIDTH(W), .HEIGHT(H), .GRID_LOG2(4), .AUTO_TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .sample(sample), .sample_valid(sample_valid),
        .trigger_level(trigger_level), .CounterX(CounterX), .CounterY(CounterY),
        .red(red), .green(green), .blue(blue), .armed(armed), .auto_trig(auto_trig)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic int ytr(int s);
        return H - 1 - s * H / 256;
    endfunction

    function automatic logic [23:0] exp_rgb(int x, int y);
        if (x >= W || y >= H) return 24'h000000;
        if (m_valid && y == ytr(disp[x])) return 24'h00FF00;
        if (x % 16 == 0 || y % 16 == 0) return 24'h404040;
        return 24'h000000;
    endfunction

    function automatic bit m_armed();
        return pend.size() == 0;
    endfunction

    function automatic void model_push(int s);
        bit rt, forced;
        if (pend.size() == 0) begin
            rt = m_prev_ok && m_prev < int'(trigger_level) && s >= int'(trigger_level);
            forced = m_cnt == 7;
            m_prev = s;
            m_prev_ok = 1;
            m_cnt++;
            if (rt || forced) begin
                pend.push_back(s);
                m_pauto = !rt;
            end
        end else if (pend.size() < W) pend.push_back(s);
    endfunction

    function automatic void model_reset();
        pend.delete();
        m_valid = 0;
        m_auto = 0;
        m_prev_ok = 0;
        m_cnt = 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int s, input int gap = 0);
        model_push(s);
        sample = 8'(s);
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic push_rand(input int n);
        for (int i = 0; i < n; i++) push(int'($urandom_range(0, 255)));
    endtask

    task automatic swap();
        CounterX = 10'd0;
        CounterY = 10'(H);
        tick();
        CounterX = 10'd700;
        CounterY = 10'd500;
        if (pend.size() == W) begin
            foreach (disp[i]) disp[i] = pend[i];
            m_valid = 1;
            m_auto = m_pauto;
            pend.delete();
            m_prev_ok = 0;
            m_cnt = 0;
        end
    endtask

    task automatic pix(input int x, input int y);
        CounterX = 10'(x);
        CounterY = 10'(y);
        tick();
        CounterX = 10'd700;
        CounterY = 10'd500;
        tick();
        chk($sformatf("pix(%0d,%0d)", x, y), {8'h00, red, green, blue}, {8'h00, exp_rgb(x, y)});
    endtask

    task automatic chk_cols(input int n);
        int c;
        for (int k = 0; k < n; k++) begin
            c = int'($urandom_range(0, W - 1));
            if (m_valid) pix(c, ytr(disp[c]));
            if (pend.size() == W) pix(c, ytr(pend[c]));
            pix(c, int'($urandom_range(0, H - 1)));
        end
    endtask

    initial begin
        // reset state
        repeat (3) tick();
        chk("rst_rgb", {red, green, blue}, 0);
        chk("rst_armed", armed, 1);
        chk("rst_auto", auto_trig, 0);
        rst_n = 1'b1;
        tick();
        pix(16, 5);
        pix(5, 5);

        // triggered capture: 50 then 120 crosses 100; column 5 holds 128
        push(50);
        chk("armed_before_edge", armed, m_armed());
        push(120);
        chk("armed_after_edge", armed, m_armed());
        for (int i = 1; i < W; i++) push(i == 5 ? 128 : int'($urandom_range(0, 255)));
        chk("armed_hold", armed, m_armed());
        pix(5, 239);
        swap();
        chk("trig_auto", auto_trig, m_auto);
        chk("armed_after_swap", armed, m_armed());
        pix(5, 239);
        pix(5, 240);
        pix(5, 238);
        chk_cols(4);

        // real edge on the timeout sample beats the forced trigger
        for (int i = 0; i < 7; i++) push(10);
        push(200);
        chk("prio_armed", armed, m_armed());
        push_rand(W - 1);
        swap();
        chk("prio_auto", auto_trig, m_auto);
        chk_cols(2);

        // no edge: forced trigger on the 8th valid sample
        for (int i = 0; i < 7; i++) push(10);
        chk("noedge_armed7", armed, m_armed());
        push(10);
        chk("noedge_armed8", armed, m_armed());
        for (int i = 1; i < W; i++) push(10);
        swap();
        chk("noedge_auto", auto_trig, m_auto);
        pix(100, 461);
        pix(100, 460);
        pix(100, 462);

        // reset in the middle of a capture
        CounterX = 10'd0;
        CounterY = 10'd0;
        push(50);
        push(120);
        push_rand(100);
        chk("pre_rst_rgb", {red, green, blue}, exp_rgb(0, 0));
        rst_n = 1'b0;
        #1;
        chk("async_rgb", {red, green, blue}, 0);
        chk("async_armed", armed, 1);
        chk("async_auto", auto_trig, 0);
        model_reset();
        repeat (2) tick();
        rst_n = 1'b1;
        CounterX = 10'd700;
        CounterY = 10'd500;
        tick();
        pix(16, 5);
        pix(5, 5);
        chk_cols(2);

        // tear-free swap: record B completes on a boundary cycle and waits a frame
        push(50);
        push(120);
        push_rand(W - 1);
        swap();
        chk_cols(3);
        push(50);
        push(120);
        push_rand(W - 2);
        pix(300, 200);
        CounterX = 10'd0;
        CounterY = 10'(H);
        push(int'($urandom_range(0, 255)));
        CounterX = 10'd700;
        CounterY = 10'd500;
        chk("tear_hold", armed, m_armed());
        chk_cols(4);
        swap();
        chk("tear_swapped", armed, m_armed());
        chk_cols(4);
        pix(0, 0);

        // gapped valid with a sawtooth ramp; level 0 only allows a forced trigger
        trigger_level = 8'd0;
        for (int i = 0; i < 7; i++) push(0);
        for (int i = 0; i < W; i++) push(i % 256, 2);
        chk("ramp_hold", armed, m_armed());
        swap();
        chk("ramp_auto", auto_trig, m_auto);
        for (int c = 0; c < W; c++) pix(c, ytr(c % 256));

        // off-screen and edge-of-screen pixels
        pix(700, ytr(disp[0]));
        pix(100, 500);
        pix(640, 0);
        pix(0, 480);
        pix(639, 479);
        pix(799, 524);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
